// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// The master drives operands and observes the product; the multiplier is the slave.
interface booth_multiplier_if #(
  parameter int OPERAND_BITS = 4
);
  logic [OPERAND_BITS-1:0]   mul1;
  logic [OPERAND_BITS-1:0]   mul2;
  logic [2*OPERAND_BITS-1:0] res_out;
  logic [2*OPERAND_BITS-1:0] comp;
  logic                      ready;

  modport master (
    output mul1, mul2,
    input  res_out, comp, ready
  );

  modport slave (
    input  mul1, mul2,
    output res_out, comp, ready
  );
endinterface

// File: rtl/booth_multiplier.sv
// Free-running radix-2 Booth signed multiplier.
// Runs LOAD -> SHIFT x N -> DONE forever. Each DONE edge publishes the Booth
// product together with a behavioural reference product, and pulses ready.
module booth_multiplier #(
  parameter int OPERAND_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  booth_multiplier_if.slave bus
);
  localparam int N  = OPERAND_BITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  // A is one bit wider than M so that subtracting M = -2^(N-1) cannot overflow.
  logic [N:0]   acc;
  logic [N:0]   mcand;
  logic [N-1:0] q;
  logic         q_m1;
  logic [CW-1:0] count;
  logic [N:0]   acc_sum;
  logic         last_step;

  // Untouched copies of the sampled operands for the reference product.
  logic signed [N-1:0]   cap1, cap2;
  logic signed [2*N-1:0] ext1, ext2, prod_ref;

  assign last_step = (count == CW'(1));
  assign ext1      = {{N{cap1[N-1]}}, cap1};
  assign ext2      = {{N{cap2[N-1]}}, cap2};
  assign prod_ref  = ext1 * ext2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next state: one load cycle, N Booth steps, one publish cycle, repeat.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Booth add/subtract selected by the current multiplier bit pair {Q0, q-1}.
  always_comb begin
    acc_sum = acc;
    case ({q[0], q_m1})
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
  end

  // Datapath and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      mcand       <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      count       <= '0;
      cap1        <= '0;
      cap2        <= '0;
      bus.res_out <= '0;
      bus.comp    <= '0;
      bus.ready   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          mcand     <= {bus.mul1[N-1], bus.mul1};
          q         <= bus.mul2;
          acc       <= '0;
          q_m1      <= 1'b0;
          count     <= CW'(N);
          cap1      <= bus.mul1;
          cap2      <= bus.mul2;
          bus.ready <= 1'b0;
        end
        SHIFT: begin
          // Arithmetic right shift of {A, Q, q-1}, replicating A's sign bit.
          acc   <= {acc_sum[N], acc_sum[N:1]};
          q     <= {acc_sum[0], q[N-1:1]};
          q_m1  <= q[0];
          count <= count - 1'b1;
        end
        DONE: begin
          bus.res_out <= {acc[N-1:0], q};
          bus.comp    <= prod_ref;
          bus.ready   <= 1'b1;
        end
        default: begin
          bus.ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier at N = 4: reset state, latency/period,
// corner operand pairs, full 256-pair sweep, mid-operation input changes and
// asynchronous reset during the SHIFT phase.
module tb_booth_multiplier;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  booth_multiplier_if #(.OPERAND_BITS(4)) bus ();

  booth_multiplier #(.OPERAND_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count rising edges until ready is seen (sampled on the falling edge), bounded.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end while (bus.ready !== 1'b1 && cyc < 40);
  endtask

  // Called on the falling edge right after a ready pulse: the operands set here
  // are captured at the following LOAD edge.
  task automatic run_pair(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
    int lat;
    bus.mul1 = a;
    bus.mul2 = b;
    wait_ready(lat);
    check({tag, "_lat"},  lat, 6);
    check({tag, "_res"},  bus.res_out, exp);
    check({tag, "_comp"}, bus.comp, exp);
  endtask

  initial begin
    int lat;
    logic signed [3:0] sa, sb;
    logic [7:0] exp;

    // Reset state
    rst      = 1'b1;
    bus.mul1 = 4'd3;
    bus.mul2 = 4'd2;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 0);
    check("rst_res",   bus.res_out, 0);
    check("rst_comp",  bus.comp, 0);

    // First product 3*2: ready six edges after release, then every six
    rst = 1'b0;
    wait_ready(lat);
    check("first_lat",  lat, 6);
    check("first_res",  bus.res_out, 8'd6);
    check("first_comp", bus.comp, 8'd6);
    wait_ready(lat);
    check("period_lat", lat, 6);
    check("hold_res",   bus.res_out, 8'd6);
    check("hold_comp",  bus.comp, 8'd6);

    // Corner pairs, hand-computed
    run_pair("m8_m8", 4'h8, 4'h8, 8'h40);
    run_pair("m8_p7", 4'h8, 4'h7, 8'hC8);
    run_pair("p7_m8", 4'h7, 4'h8, 8'hC8);
    run_pair("m1_m1", 4'hF, 4'hF, 8'h01);
    run_pair("z_m5",  4'h0, 4'hB, 8'h00);

    // Full sweep of all signed 4-bit operand pairs
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        sa  = 4'(ai);
        sb  = 4'(bi);
        exp = 8'(int'(sa) * int'(sb));
        run_pair($sformatf("sweep_%0d_%0d", sa, sb), sa, sb, exp);
      end
    end

    // Operands change after the LOAD edge: result must reflect 5 * -3 only
    bus.mul1 = 4'd5;
    bus.mul2 = 4'hD;
    @(posedge clk);
    @(negedge clk);
    bus.mul1 = 4'h9;
    bus.mul2 = 4'd6;
    wait_ready(lat);
    check("midchg_lat",  lat, 5);
    check("midchg_res",  bus.res_out, 8'hF1);
    check("midchg_comp", bus.comp, 8'hF1);

    // Asynchronous reset during SHIFT clears outputs without a clock edge
    bus.mul1 = 4'd3;
    bus.mul2 = 4'd3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_ready", bus.ready, 0);
    check("arst_res",   bus.res_out, 0);
    check("arst_comp",  bus.comp, 0);
    bus.mul1 = 4'd2;
    bus.mul2 = 4'hC;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(lat);
    check("arst_lat",  lat, 6);
    check("arst_res2", bus.res_out, 8'hF8);
    check("arst_comp2", bus.comp, 8'hF8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
